// File: rtl/alu_pkg.sv
// Shared opcode encodings for the 32-bit ALU and anything that drives it.
// Reserved codes are named so decoders and benches agree on them.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'b00000,
        OP_SUB   = 5'b00001,
        OP_SEQ   = 5'b00010,
        OP_SLT   = 5'b00011,
        OP_SLE   = 5'b00100,
        OP_SGT   = 5'b00101,
        OP_SGE   = 5'b00110,
        OP_SLTU  = 5'b00111,
        OP_SLEU  = 5'b01000,
        OP_SGTU  = 5'b01001,
        OP_SGEU  = 5'b01010,
        OP_NOT   = 5'b01011,
        OP_AND   = 5'b01100,
        OP_NAND  = 5'b01101,
        OP_OR    = 5'b01110,
        OP_NOR   = 5'b01111,
        OP_XOR   = 5'b10000,
        OP_XNOR  = 5'b10001,
        OP_SLL   = 5'b10010,
        OP_SRL   = 5'b10011,
        OP_SRA   = 5'b10100,
        OP_MUL   = 5'b10101,
        OP_MULH  = 5'b10110,
        OP_MULU  = 5'b10111,
        OP_RSV0  = 5'b11000,
        OP_RSV1  = 5'b11001,
        OP_DIV   = 5'b11010,
        OP_DIVU  = 5'b11011,
        OP_REM   = 5'b11100,
        OP_REMU  = 5'b11101,
        OP_RSV2  = 5'b11110,
        OP_RSV3  = 5'b11111
    } alu_op_e;

    function automatic logic is_reserved(logic [4:0] op);
        return op inside {OP_RSV0, OP_RSV1, OP_RSV2, OP_RSV3};
    endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle for the ALU; master drives operands, slave returns the result.
interface alu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  ALUOp;
    logic [31:0] ALUOut;

    modport master (output A, B, ALUOp, input ALUOut);
    modport slave  (input A, B, ALUOp, output ALUOut);
endinterface

// File: rtl/alu_div32.sv
// Single-cycle combinational divider: signed and unsigned quotient/remainder,
// with divide-by-zero returning all-ones quotient and the dividend as remainder.
module alu_div32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] quot_s,
    output logic [31:0] rem_s,
    output logic [31:0] quot_u,
    output logic [31:0] rem_u
);
    logic        b_zero;
    logic [31:0] mag_a, mag_b, dvs_u, dvs_m, q_m, r_m;

    assign b_zero = (b == 32'd0);
    assign mag_a  = a[31] ? -a : a;
    assign mag_b  = b[31] ? -b : b;

    // Keep the divider away from a zero divisor; the b_zero mux supplies the result.
    assign dvs_u  = b_zero ? 32'd1 : b;
    assign dvs_m  = b_zero ? 32'd1 : mag_b;
    assign q_m    = mag_a / dvs_m;
    assign r_m    = mag_a % dvs_m;

    assign quot_u = b_zero ? 32'hFFFF_FFFF : a / dvs_u;
    assign rem_u  = b_zero ? a : a % dvs_u;

    // 0x80000000 / -1 falls out as magnitude 0x80000000, negated back to itself, rem 0.
    assign quot_s = b_zero ? 32'hFFFF_FFFF : ((a[31] ^ b[31]) ? -q_m : q_m);
    assign rem_s  = b_zero ? a : (a[31] ? -r_m : r_m);
endmodule

// File: rtl/alu_32bit.sv
// 32-bit ALU with a single registered result; every opcode resolves in one cycle.
module alu_32bit
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  ALUOp,
    output logic [31:0] ALUOut
);
    logic        lt_s, lt_u, eq;
    logic [63:0] prod_s;
    logic [31:0] mulhu;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;
    logic [31:0] result;

    assign eq   = (A == B);
    assign lt_s = ($signed(A) < $signed(B));
    assign lt_u = (A < B);

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    // Unsigned high word recovered from the signed product instead of a second multiplier.
    assign mulhu  = prod_s[63:32] + (A[31] ? B : 32'd0) + (B[31] ? A : 32'd0);

    alu_div32 u_div (
        .a      (A),
        .b      (B),
        .quot_s (quot_s),
        .rem_s  (rem_s),
        .quot_u (quot_u),
        .rem_u  (rem_u)
    );

    always_comb begin
        result = 32'd0;
        case (ALUOp)
            OP_ADD:  result = A + B;
            OP_SUB:  result = A - B;
            OP_SEQ:  result = {31'd0, eq};
            OP_SLT:  result = {31'd0, lt_s};
            OP_SLE:  result = {31'd0, lt_s | eq};
            OP_SGT:  result = {31'd0, ~(lt_s | eq)};
            OP_SGE:  result = {31'd0, ~lt_s};
            OP_SLTU: result = {31'd0, lt_u};
            OP_SLEU: result = {31'd0, lt_u | eq};
            OP_SGTU: result = {31'd0, ~(lt_u | eq)};
            OP_SGEU: result = {31'd0, ~lt_u};
            OP_NOT:  result = ~A;
            OP_AND:  result = A & B;
            OP_NAND: result = ~(A & B);
            OP_OR:   result = A | B;
            OP_NOR:  result = ~(A | B);
            OP_XOR:  result = A ^ B;
            OP_XNOR: result = ~(A ^ B);
            OP_SLL:  result = A << B[4:0];
            OP_SRL:  result = A >> B[4:0];
            OP_SRA:  result = $signed(A) >>> B[4:0];
            OP_MUL:  result = prod_s[31:0];
            OP_MULH: result = prod_s[63:32];
            OP_MULU: result = mulhu;
            OP_DIV:  result = quot_s;
            OP_DIVU: result = quot_u;
            OP_REM:  result = rem_s;
            OP_REMU: result = rem_u;
            default: result = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ALUOut <= 32'd0;
        else        ALUOut <= result;
    end
endmodule

// File: tb/tb_alu_32bit.sv
// Scoreboard bench for alu_32bit: directed corners plus random ops against a
// 64-bit arithmetic reference model.
module tb_alu_32bit;
    import alu_pkg::*;

    typedef struct {
        string       tag;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic issued = 1'b0;
    logic mon_v;
    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];

    alu_if bus ();

    alu_32bit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (bus.A),
        .B      (bus.B),
        .ALUOp  (bus.ALUOp),
        .ALUOut (bus.ALUOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, t;
        logic [63:0] pu;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        pu = {32'd0, a} * {32'd0, b};
        t  = sa * sb;
        r  = 32'd0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SEQ:  r = (a == b)  ? 32'd1 : 32'd0;
            OP_SLT:  r = (sa < sb)  ? 32'd1 : 32'd0;
            OP_SLE:  r = (sa <= sb) ? 32'd1 : 32'd0;
            OP_SGT:  r = (sa > sb)  ? 32'd1 : 32'd0;
            OP_SGE:  r = (sa >= sb) ? 32'd1 : 32'd0;
            OP_SLTU: r = (a < b)  ? 32'd1 : 32'd0;
            OP_SLEU: r = (a <= b) ? 32'd1 : 32'd0;
            OP_SGTU: r = (a > b)  ? 32'd1 : 32'd0;
            OP_SGEU: r = (a >= b) ? 32'd1 : 32'd0;
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_NAND: r = ~(a & b);
            OP_OR:   r = a | b;
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_SLL:  r = a << b[4:0];
            OP_SRL:  r = a >> b[4:0];
            OP_SRA:  r = 32'(sa >>> b[4:0]);
            OP_MUL:  r = t[31:0];
            OP_MULH: r = t[63:32];
            OP_MULU: r = pu[63:32];
            OP_DIV:  r = (b == 32'd0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            OP_DIVU: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:  r = (b == 32'd0) ? a : 32'(sa % sb);
            OP_REMU: r = (b == 32'd0) ? a : a % b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.ALUOp = op;
        issued = 1'b1;
        e.tag = tag; e.op = op; e.a = a; e.b = b; e.exp = exp;
        expq.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        issued = 1'b0;
    endtask

    // Monitor: a result is due one edge after any cycle the stimulus issued out of reset.
    always @(posedge clk) begin
        exp_t e;
        mon_v = issued && rst_n;
        #1;
        if (mon_v) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty got=%h", bus.ALUOut);
            end else begin
                e = expq.pop_front();
                chk($sformatf("%s op=%05b a=%h b=%h", e.tag, e.op, e.a, e.b), bus.ALUOut, e.exp);
            end
        end
    end

    logic [4:0]  dop  [28];
    logic [31:0] dexp [28];

    initial begin
        bus.A = 32'd0;
        bus.B = 32'd0;
        bus.ALUOp = 5'd0;

        @(posedge clk);
        #1 chk("reset_state", bus.ALUOut, 32'd0);
        bus.A = 32'd123; bus.B = 32'd456;
        @(posedge clk);
        #1 chk("reset_hold", bus.ALUOut, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        dop  = '{OP_ADD, OP_SUB, OP_SEQ, OP_SLT, OP_SLE, OP_SGT, OP_SGE,
                 OP_SLTU, OP_SLEU, OP_SGTU, OP_SGEU,
                 OP_NOT, OP_AND, OP_NAND, OP_OR, OP_NOR, OP_XOR, OP_XNOR,
                 OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_MULH, OP_MULU,
                 OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        dexp = '{32'd15, 32'd5, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1,
                 32'd0, 32'd0, 32'd1, 32'd1,
                 32'hFFFF_FFF5, 32'd0, 32'hFFFF_FFFF, 32'd15, 32'hFFFF_FFF0, 32'd15, 32'hFFFF_FFF0,
                 32'd320, 32'd0, 32'd0, 32'd50, 32'd0, 32'd0,
                 32'd2, 32'd2, 32'd0, 32'd0};
        for (int i = 0; i < 28; i++) issue("all_ops", dop[i], 32'd10, 32'd5, dexp[i]);

        issue("slt_neg",  OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1);
        issue("sltu_big", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        issue("sra4",     OP_SRA,  32'hFFFF_FFFF, 32'd4, 32'hFFFF_FFFF);
        issue("srl4",     OP_SRL,  32'hFFFF_FFFF, 32'd4, 32'h0FFF_FFFF);
        issue("mulh_neg", OP_MULH, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
        issue("mulu_big", OP_MULU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        issue("div_by0",  OP_DIV,  32'd7, 32'd0, 32'hFFFF_FFFF);
        issue("rem_by0",  OP_REM,  32'd7, 32'd0, 32'd7);
        issue("divu_by0", OP_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF);
        issue("remu_by0", OP_REMU, 32'd7, 32'd0, 32'd7);
        issue("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        issue("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        issue("div_neg",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        issue("rem_neg",  OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        issue("sll_mask", OP_SLL,  32'd1, 32'd33, 32'd2);
        issue("rsv0", OP_RSV0, 32'd10, 32'd5, 32'd0);
        issue("rsv1", OP_RSV1, 32'd10, 32'd5, 32'd0);
        issue("rsv2", OP_RSV2, 32'd10, 32'd5, 32'd0);
        issue("rsv3", OP_RSV3, 32'd10, 32'd5, 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            op = 5'($urandom_range(0, 31));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: a = 32'h8000_0000;
                1: b = 32'd0;
                2: b = 32'hFFFF_FFFF;
                3: begin a = 32'($urandom_range(0, 20)); b = 32'($urandom_range(0, 20)); end
                4: b = a;
                default: ;
            endcase
            issue("random", op, a, b, model(op, a, b));
        end

        // Mid-stream reset: ADD result lands, then reset between edges clears it at once.
        issue("pre_reset_add", OP_ADD, 32'd10, 32'd5, 32'd15);
        @(negedge clk);
        issued = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("reset_async", bus.ALUOut, 32'd0);
        @(posedge clk);
        #1 chk("reset_hold_edge", bus.ALUOut, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issued = 1'b1;
        begin
            exp_t e;
            e.tag = "post_reset_add"; e.op = OP_ADD; e.a = 32'd10; e.b = 32'd5; e.exp = 32'd15;
            expq.push_back(e);
        end
        idle();
        repeat (3) @(negedge clk);

        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", expq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
